// File: rtl/wb_pkg.sv
// Shared definitions for the MEM/WB writeback stage: bus field offsets,
// FSM state encoding and the hold-buffer entry layout.
package wb_pkg;

   localparam int unsigned MWB_W    = 71;
   localparam int unsigned XLEN     = 32;
   localparam int unsigned REG_W    = 5;

   localparam int unsigned WB_BIT   = 70;
   localparam int unsigned CALL_BIT = 69;
   localparam int unsigned PC_MSB   = 68;
   localparam int unsigned PC_LSB   = 37;
   localparam int unsigned LD_MSB   = 36;
   localparam int unsigned LD_LSB   = 5;
   localparam int unsigned RD_MSB   = 4;
   localparam int unsigned RD_LSB   = 0;

   typedef enum logic {
      PASS = 1'b0,
      HOLD = 1'b1
   } wb_state_e;

   // A deferred pipeline write waiting for the RF port.
   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  data;
   } wb_entry_t;

endpackage

// File: rtl/mwb_unpack.sv
// Combinational unpack of the MEM/WB bus into write-enable, destination index
// and write data (link address for calls, load/ALU result otherwise).
module mwb_unpack
   import wb_pkg::*;
#(
   parameter int unsigned LINK_OFFSET = 4
) (
   input  logic [MWB_W-1:0] bus_i,
   output logic             is_write_o,
   output logic [REG_W-1:0] rd_o,
   output logic [XLEN-1:0]  wdata_o
);

   logic            wb_flag;
   logic            is_call;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] load_data;

   assign wb_flag   = bus_i[WB_BIT];
   assign is_call   = bus_i[CALL_BIT];
   assign pc        = bus_i[PC_MSB:PC_LSB];
   assign load_data = bus_i[LD_MSB:LD_LSB];
   assign rd_o      = bus_i[RD_MSB:RD_LSB];

   // x0 is hardwired, so a write to it is no write at all.
   assign is_write_o = wb_flag && (rd_o != '0);
   assign wdata_o    = is_call ? (pc + XLEN'(LINK_OFFSET)) : load_data;

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB consumer: drives the single RF write port, arbitrating pipeline beats
// against debug writes via a one-entry hold buffer. Optional macro WB_FWD_EN
// adds EX-stage bypass outputs.
module mem_wb_writeback
   import wb_pkg::*;
#(
   parameter int unsigned LINK_OFFSET = 4,
   parameter int unsigned CNT_W       = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [MWB_W-1:0]   M_WB_register,
   input  logic               mwb_valid,
   output logic               mwb_ready,
   input  logic               dbg_we,
   input  logic [REG_W-1:0]   dbg_addr,
   input  logic [XLEN-1:0]    dbg_data,
   output logic               rf_we,
   output logic [REG_W-1:0]   rf_waddr,
   output logic [XLEN-1:0]    rf_wdata,
   output logic [CNT_W-1:0]   retired_count
`ifdef WB_FWD_EN
   ,
   output logic               fwd_valid,
   output logic [REG_W-1:0]   fwd_rd,
   output logic [XLEN-1:0]    fwd_data
`endif
);

   wb_state_e        state_q;
   wb_entry_t        hold_q;
   logic             rf_we_q;
   logic [REG_W-1:0] rf_waddr_q;
   logic [XLEN-1:0]  rf_wdata_q;
   logic [CNT_W-1:0] cnt_q;
   logic             fwd_valid_q;

   logic             beat_write;
   logic [REG_W-1:0] beat_rd;
   logic [XLEN-1:0]  beat_wdata;
   logic             accept;

   mwb_unpack #(
      .LINK_OFFSET (LINK_OFFSET)
   ) u_unpack (
      .bus_i      (M_WB_register),
      .is_write_o (beat_write),
      .rd_o       (beat_rd),
      .wdata_o    (beat_wdata)
   );

   // Ready is a pure decode of the state register: high only while the hold is empty.
   assign mwb_ready = (state_q == PASS);
   assign accept    = mwb_valid && mwb_ready;

   // Arbitration FSM, hold buffer, RF port registers and retire counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= PASS;
         hold_q      <= '0;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
         cnt_q       <= '0;
         fwd_valid_q <= 1'b0;
      end else begin
         fwd_valid_q <= 1'b0;
         if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end

         if (dbg_we) begin
            // Debug always wins; a debug write to x0 still consumes the port.
            rf_we_q    <= (dbg_addr != '0);
            rf_waddr_q <= dbg_addr;
            rf_wdata_q <= dbg_data;
            if (state_q == PASS && accept && beat_write) begin
               hold_q  <= '{rd: beat_rd, data: beat_wdata};
               state_q <= HOLD;
            end
         end else if (state_q == HOLD) begin
            rf_we_q     <= 1'b1;
            rf_waddr_q  <= hold_q.rd;
            rf_wdata_q  <= hold_q.data;
            fwd_valid_q <= 1'b1;
            state_q     <= PASS;
         end else if (accept) begin
            rf_we_q     <= beat_write;
            rf_waddr_q  <= beat_rd;
            rf_wdata_q  <= beat_wdata;
            fwd_valid_q <= beat_write;
         end else begin
            rf_we_q <= 1'b0;
         end
      end
   end

   assign rf_we         = rf_we_q;
   assign rf_waddr      = rf_waddr_q;
   assign rf_wdata      = rf_wdata_q;
   assign retired_count = cnt_q;

`ifdef WB_FWD_EN
   assign fwd_valid = fwd_valid_q;
   assign fwd_rd    = rf_waddr_q;
   assign fwd_data  = rf_wdata_q;
`else
   logic unused_fwd;
   assign unused_fwd = fwd_valid_q;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: directed scenarios then random
// traffic against a queue-based reference model. Covers WB_FWD_EN when defined.
module tb_mem_wb_writeback;

   localparam int unsigned CW = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic [70:0]      M_WB_register;
   logic             mwb_valid;
   logic             mwb_ready;
   logic             dbg_we;
   logic [4:0]       dbg_addr;
   logic [31:0]      dbg_data;
   logic             rf_we;
   logic [4:0]       rf_waddr;
   logic [31:0]      rf_wdata;
   logic [CW-1:0]    retired_count;
`ifdef WB_FWD_EN
   logic             fwd_valid;
   logic [4:0]       fwd_rd;
   logic [31:0]      fwd_data;
`endif

   mem_wb_writeback #(.LINK_OFFSET(4), .CNT_W(CW)) dut (
      .clock         (clock),
      .reset         (reset),
      .M_WB_register (M_WB_register),
      .mwb_valid     (mwb_valid),
      .mwb_ready     (mwb_ready),
      .dbg_we        (dbg_we),
      .dbg_addr      (dbg_addr),
      .dbg_data      (dbg_data),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .retired_count (retired_count)
`ifdef WB_FWD_EN
      ,
      .fwd_valid     (fwd_valid),
      .fwd_rd        (fwd_rd),
      .fwd_data      (fwd_data)
`endif
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   ent_t        pend[$];
   logic        e_we, e_fv, e_ready;
   logic [4:0]  e_addr;
   logic [31:0] e_data;
   int          e_cnt;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model by the same edge, compare after it.
   task automatic step(input logic rst, input logic v, input logic wb, input logic call,
                       input logic [31:0] pc, input logic [31:0] ld, input logic [4:0] rd,
                       input logic dw, input logic [4:0] da, input logic [31:0] dd);
      ent_t e;
      reset         = rst;
      mwb_valid     = v;
      M_WB_register = {wb, call, pc, ld, rd};
      dbg_we        = dw;
      dbg_addr      = da;
      dbg_data      = dd;
      @(posedge clock);
      if (rst) begin
         pend.delete();
         e_we = 0; e_addr = 0; e_data = 0; e_cnt = 0; e_fv = 0;
      end else begin
         if (v && pend.size() == 0) begin
            e_cnt = (e_cnt + 1) % (1 << CW);
            e.we = wb && (rd != 0);
            e.rd = rd;
            e.d  = call ? pc + 32'd4 : ld;
            pend.push_back(e);
         end
         if (dw) begin
            e_we = (da != 0); e_addr = da; e_data = dd; e_fv = 0;
            for (int i = pend.size() - 1; i >= 0; i--)
               if (!pend[i].we) pend.delete(i);
         end else if (pend.size() > 0) begin
            e = pend.pop_front();
            e_we = e.we; e_addr = e.rd; e_data = e.d; e_fv = e.we;
         end else begin
            e_we = 0; e_fv = 0;
         end
      end
      e_ready = (pend.size() == 0);
      #1;
      chk("rf_we",    32'(rf_we),         32'(e_we));
      chk("rf_waddr", 32'(rf_waddr),      32'(e_addr));
      chk("rf_wdata", rf_wdata,           e_data);
      chk("ready",    32'(mwb_ready),     32'(e_ready));
      chk("count",    32'(retired_count), 32'(e_cnt));
`ifdef WB_FWD_EN
      chk("fwd_valid", 32'(fwd_valid), 32'(e_fv));
      if (e_fv) begin
         chk("fwd_rd",   32'(fwd_rd), 32'(e_addr));
         chk("fwd_data", fwd_data,    e_data);
      end
`endif
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   logic        cv, cwb, ccall, cdw;
   logic [31:0] cpc, cld, cdd;
   logic [4:0]  crd, cda;

   initial begin
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_we",    32'(rf_we), 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_ready", 32'(mwb_ready), 1);
      chk("rst_count", 32'(retired_count), 0);

      // Plain load write, then call with pc wrap, then non-write beats.
      step(0, 1, 1, 0, 32'h100, 32'hDEADBEEF, 5, 0, 0, 0);
      chk("ld_we", 32'(rf_we), 1);
      chk("ld_data", rf_wdata, 32'hDEADBEEF);
      chk("ld_cnt", 32'(retired_count), 1);
      step(0, 1, 1, 1, 32'hFFFFFFFC, 32'h55, 1, 0, 0, 0);
      chk("call_wrap", rf_wdata, 32'h0);
      chk("call_rd", 32'(rf_waddr), 1);
      step(0, 1, 1, 0, 32'h0, 32'h77, 0, 0, 0, 0);
      chk("x0_we", 32'(rf_we), 0);
      step(0, 1, 0, 0, 32'h0, 32'h78, 4, 0, 0, 0);
      chk("nowb_we", 32'(rf_we), 0);
      chk("nowb_cnt", 32'(retired_count), 4);
      idle();

      // Collision: debug wins, beat held; three more debug cycles starve it.
      step(0, 1, 1, 0, 32'h0, 32'h11, 7, 1, 3, 32'h22);
      chk("col_addr", 32'(rf_waddr), 3);
      chk("col_data", rf_wdata, 32'h22);
      chk("col_ready", 32'(mwb_ready), 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 0, 0, 1, 5'(10 + i), 32'(100 + i));
         chk("starve_ready", 32'(mwb_ready), 0);
      end
      idle();
      chk("held_addr", 32'(rf_waddr), 7);
      chk("held_data", rf_wdata, 32'h11);
      chk("held_ready", 32'(mwb_ready), 1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h99);
      chk("dbg_x0_we", 32'(rf_we), 0);

      // Counter wrap at CW bits.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 17; i++) step(0, 1, 1, 0, 0, 32'(i), 5'(i + 1), 0, 0, 0);
      chk("cnt_wrap", 32'(retired_count), 1);

      // Reset while holding discards the held write.
      step(0, 1, 1, 0, 0, 32'hABCD, 9, 1, 2, 32'h1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rh_we", 32'(rf_we), 0);
      chk("rh_addr", 32'(rf_waddr), 0);
      chk("rh_data", rf_wdata, 0);
      chk("rh_ready", 32'(mwb_ready), 1);
      idle();
      chk("rh_nowrite", 32'(rf_we), 0);
      idle();
      chk("rh_nowrite2", 32'(rf_we), 0);

`ifdef WB_FWD_EN
      step(0, 1, 1, 0, 0, 32'h909, 9, 0, 0, 0);
      chk("fwd_pipe_v", 32'(fwd_valid), 1);
      chk("fwd_pipe_rd", 32'(fwd_rd), 9);
      step(0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h6);
      chk("fwd_dbg_v", 32'(fwd_valid), 0);
`endif

      // Random traffic; the bus is held stable while not accepted.
      cv = 0; cwb = 0; ccall = 0; cpc = 0; cld = 0; crd = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!(cv && !e_ready)) begin
            cv    = ($urandom_range(0, 3) != 0);
            cwb   = ($urandom_range(0, 7) != 0);
            ccall = ($urandom_range(0, 3) == 0);
            cpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
            cld   = $urandom;
            crd   = 5'($urandom_range(0, 31));
         end
         cdw = ($urandom_range(0, 3) == 0);
         cda = 5'($urandom_range(0, 31));
         cdd = $urandom;
         step(($urandom_range(0, 199) == 0), cv, cwb, ccall, cpc, cld, crd, cdw, cda, cdd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
